// File: rtl/muldiv_commit_gather_pkg.sv
// Shared widths and types for the mul/div commit gather.
// Core-wide lane and tag widths live here; warps/lanes are per instance.
package muldiv_commit_gather_pkg;

    localparam int NUM_THREADS = 4;
    localparam int XLEN        = 32;
    localparam int UUID_WIDTH  = 44;
    localparam int PC_BITS     = 30;
    localparam int NR_BITS     = 6;
    localparam int RRS_WIS_W   = 2;

    typedef enum logic {
        CTX_IDLE  = 1'b0,
        CTX_ACCUM = 1'b1
    } ctx_state_e;

    typedef struct packed {
        logic [UUID_WIDTH-1:0]       uuid;
        logic [PC_BITS-1:0]          pc;
        logic [NR_BITS-1:0]          rd;
        logic                        wb;
        logic [RRS_WIS_W-1:0]        rrs_id;
        logic [NUM_THREADS-1:0]      tmask;
        logic [NUM_THREADS*XLEN-1:0] data;
    } gather_ctx_t;

    function automatic int pid_width(input int lanes);
        int packets;
        packets = NUM_THREADS / lanes;
        return (packets > 1) ? $clog2(packets) : 1;
    endfunction

endpackage

// File: rtl/muldiv_gather_ctx.sv
// One warp gather context: tag latch on sop, lane placement by pid.
// merged is this context combined with the packet currently presented.
module muldiv_gather_ctx
    import muldiv_commit_gather_pkg::*;
#(
    parameter int NUM_LANES = 1,
    parameter int PID_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hit,
    input  logic                      sop,
    input  logic                      eop,
    input  logic [PID_WIDTH-1:0]      pid,
    input  logic [UUID_WIDTH-1:0]     uuid,
    input  logic [PC_BITS-1:0]        pc,
    input  logic [NR_BITS-1:0]        rd,
    input  logic                      wb,
    input  logic [RRS_WIS_W-1:0]      rrs_id,
    input  logic [NUM_LANES-1:0]      tmask,
    input  logic [NUM_LANES*XLEN-1:0] data,
    output gather_ctx_t               merged,
    output logic                      emit,
    output logic                      proto_err
);

    ctx_state_e  state;
    ctx_state_e  state_next;
    gather_ctx_t ctx_q;
    logic        drop;
    logic        load;

    assign drop      = (state == CTX_IDLE) & ~sop;
    assign emit      = hit & eop & ~drop;
    assign load      = hit & ~drop & ~eop;
    assign proto_err = hit & (drop | ((state == CTX_ACCUM) & sop));

    always_comb begin
        merged = ctx_q;
        if (sop) begin
            merged.uuid   = uuid;
            merged.pc     = pc;
            merged.rd     = rd;
            merged.wb     = wb;
            merged.rrs_id = rrs_id;
            merged.tmask  = '0;
        end
        // out lane t belongs to packet t/NUM_LANES, in lane t%NUM_LANES
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (PID_WIDTH'(t / NUM_LANES) == pid) begin
                merged.tmask[t] = tmask[t % NUM_LANES];
                merged.data[t*XLEN +: XLEN] =
                    data[(t % NUM_LANES)*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        state_next = state;
        if (hit && !drop) begin
            state_next = eop ? CTX_IDLE : CTX_ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= CTX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctx_q.tmask <= '0;
        end else if (load) begin
            ctx_q <= merged;
        end
    end

endmodule

// File: rtl/muldiv_commit_gather.sv
// Gathers partial mul/div commit packets into full-warp writebacks.
// One context per warp feeds a single registered valid/ready output.
module muldiv_commit_gather
    import muldiv_commit_gather_pkg::*;
#(
    parameter int  NUM_WARPS = 4,
    parameter int  NUM_LANES = 1,
    localparam int PID_WIDTH = pid_width(NUM_LANES),
    localparam int WID_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [UUID_WIDTH-1:0]       in_uuid,
    input  logic [WID_WIDTH-1:0]        in_wid,
    input  logic [NUM_LANES-1:0]        in_tmask,
    input  logic [PC_BITS-1:0]          in_PC,
    input  logic [NR_BITS-1:0]          in_rd,
    input  logic                        in_wb,
    input  logic [PID_WIDTH-1:0]        in_pid,
    input  logic                        in_sop,
    input  logic                        in_eop,
    input  logic [RRS_WIS_W-1:0]        in_rrs_id,
    input  logic [NUM_LANES*XLEN-1:0]   in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [UUID_WIDTH-1:0]       out_uuid,
    output logic [WID_WIDTH-1:0]        out_wid,
    output logic [NUM_THREADS-1:0]      out_tmask,
    output logic [PC_BITS-1:0]          out_PC,
    output logic [NR_BITS-1:0]          out_rd,
    output logic                        out_wb,
    output logic [RRS_WIS_W-1:0]        out_rrs_id,
    output logic [NUM_THREADS*XLEN-1:0] out_data,
    output logic                        err
);

    logic                 fire;
    logic [NUM_WARPS-1:0] hit;
    logic [NUM_WARPS-1:0] emit;
    logic [NUM_WARPS-1:0] perr;
    gather_ctx_t          merged [NUM_WARPS];
    gather_ctx_t          out_q;
    logic [WID_WIDTH-1:0] wid_q;
    logic                 out_valid_q;
    logic                 err_q;

    // only an eop needs the output slot, so only an eop can stall
    assign in_ready = ~in_eop | ~out_valid_q | out_ready;
    assign fire     = in_valid & in_ready;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_ctx
        assign hit[w] = fire & (in_wid == WID_WIDTH'(w));

        muldiv_gather_ctx #(
            .NUM_LANES (NUM_LANES),
            .PID_WIDTH (PID_WIDTH)
        ) u_ctx (
            .clk       (clk),
            .reset     (reset),
            .hit       (hit[w]),
            .sop       (in_sop),
            .eop       (in_eop),
            .pid       (in_pid),
            .uuid      (in_uuid),
            .pc        (in_PC),
            .rd        (in_rd),
            .wb        (in_wb),
            .rrs_id    (in_rrs_id),
            .tmask     (in_tmask),
            .data      (in_data),
            .merged    (merged[w]),
            .emit      (emit[w]),
            .proto_err (perr[w])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (|emit) begin
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (|perr) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (|emit) begin
            out_q <= merged[in_wid];
            wid_q <= in_wid;
        end
    end

    assign out_valid  = out_valid_q;
    assign err        = err_q;
    assign out_uuid   = out_q.uuid;
    assign out_wid    = wid_q;
    assign out_tmask  = out_q.tmask;
    assign out_PC     = out_q.pc;
    assign out_rd     = out_q.rd;
    assign out_wb     = out_q.wb;
    assign out_rrs_id = out_q.rrs_id;
    assign out_data   = out_q.data;

endmodule

// File: tb/tb_muldiv_commit_gather.sv
// Bench for muldiv_commit_gather: directed cases, random traffic,
// and a full-width pass-through instance.
module tb_muldiv_commit_gather;
    import muldiv_commit_gather_pkg::*;

    localparam int NW = 4;
    localparam int PA = pid_width(1);
    localparam int PB = pid_width(4);
    localparam int DW = NUM_THREADS * XLEN;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic                  in_valid, in_ready;
    logic [UUID_WIDTH-1:0] in_uuid;
    logic [1:0]            in_wid;
    logic [0:0]            in_tmask;
    logic [PC_BITS-1:0]    in_pc;
    logic [NR_BITS-1:0]    in_rd;
    logic                  in_wb;
    logic [PA-1:0]         in_pid;
    logic                  in_sop, in_eop;
    logic [RRS_WIS_W-1:0]  in_rrs_id;
    logic [XLEN-1:0]       in_data;
    logic                  out_valid, out_ready;
    logic [UUID_WIDTH-1:0] out_uuid;
    logic [1:0]            out_wid;
    logic [3:0]            out_tmask;
    logic [PC_BITS-1:0]    out_pc;
    logic [NR_BITS-1:0]    out_rd;
    logic                  out_wb;
    logic [RRS_WIS_W-1:0]  out_rrs_id;
    logic [DW-1:0]         out_data;
    logic                  err;

    logic                  b_in_valid, b_in_ready;
    logic [UUID_WIDTH-1:0] b_in_uuid;
    logic [1:0]            b_in_wid;
    logic [3:0]            b_in_tmask;
    logic [PC_BITS-1:0]    b_in_pc;
    logic [NR_BITS-1:0]    b_in_rd;
    logic                  b_in_wb;
    logic [PB-1:0]         b_in_pid;
    logic                  b_in_sop, b_in_eop;
    logic [RRS_WIS_W-1:0]  b_in_rrs_id;
    logic [DW-1:0]         b_in_data;
    logic                  b_out_valid, b_out_ready;
    logic [UUID_WIDTH-1:0] b_out_uuid;
    logic [1:0]            b_out_wid;
    logic [3:0]            b_out_tmask;
    logic [PC_BITS-1:0]    b_out_pc;
    logic [NR_BITS-1:0]    b_out_rd;
    logic                  b_out_wb;
    logic [RRS_WIS_W-1:0]  b_out_rrs_id;
    logic [DW-1:0]         b_out_data;
    logic                  b_err;

    muldiv_commit_gather #(.NUM_WARPS(NW), .NUM_LANES(1)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_uuid(in_uuid),
        .in_wid(in_wid), .in_tmask(in_tmask), .in_PC(in_pc),
        .in_rd(in_rd), .in_wb(in_wb), .in_pid(in_pid),
        .in_sop(in_sop), .in_eop(in_eop), .in_rrs_id(in_rrs_id),
        .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_uuid(out_uuid), .out_wid(out_wid), .out_tmask(out_tmask),
        .out_PC(out_pc), .out_rd(out_rd), .out_wb(out_wb),
        .out_rrs_id(out_rrs_id), .out_data(out_data), .err(err)
    );

    muldiv_commit_gather #(.NUM_WARPS(NW), .NUM_LANES(4)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_uuid(b_in_uuid), .in_wid(b_in_wid), .in_tmask(b_in_tmask),
        .in_PC(b_in_pc), .in_rd(b_in_rd), .in_wb(b_in_wb),
        .in_pid(b_in_pid), .in_sop(b_in_sop), .in_eop(b_in_eop),
        .in_rrs_id(b_in_rrs_id), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_uuid(b_out_uuid), .out_wid(b_out_wid),
        .out_tmask(b_out_tmask), .out_PC(b_out_pc), .out_rd(b_out_rd),
        .out_wb(b_out_wb), .out_rrs_id(b_out_rrs_id),
        .out_data(b_out_data), .err(b_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        gather_ctx_t c;
        logic [1:0]  wid;
    } exp_t;

    exp_t        exp_q[$];
    gather_ctx_t acc[NW];
    logic [1:0]  acc_wid[NW];
    bit          act[NW];
    logic        exp_err;
    bit          mon_en = 1'b0;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] lane_mask(input logic [3:0] m);
        logic [DW-1:0] r;
        r = '0;
        for (int t = 0; t < NUM_THREADS; t++)
            if (m[t]) r[t*XLEN +: XLEN] = '1;
        return r;
    endfunction

    // scoreboard: exactly one merged result is pending per valid output
    always @(negedge clk) begin
        if (mon_en) begin
            chk("pending", out_valid, exp_q.size() != 0);
            chk("err", err, exp_err);
            if (out_valid && out_ready && exp_q.size() > 0) begin
                exp_t e;
                logic [DW-1:0] m;
                e = exp_q.pop_front();
                m = lane_mask(e.c.tmask);
                chk("out_tmask", out_tmask, e.c.tmask);
                chk("out_data", out_data & m, e.c.data & m);
                chk("out_uuid", out_uuid, e.c.uuid);
                chk("out_pc", out_pc, e.c.pc);
                chk("out_rd", out_rd, e.c.rd);
                chk("out_wb", out_wb, e.c.wb);
                chk("out_rrs", out_rrs_id, e.c.rrs_id);
                chk("out_wid", out_wid, e.wid);
            end
        end
    end

    task automatic model_update();
        int w;
        int p;
        w = int'(in_wid);
        p = int'(in_pid);
        if (!in_sop && !act[w]) begin
            exp_err = 1'b1;
            return;
        end
        if (in_sop) begin
            if (act[w]) exp_err = 1'b1;
            acc[w].uuid   = in_uuid;
            acc[w].pc     = in_pc;
            acc[w].rd     = in_rd;
            acc[w].wb     = in_wb;
            acc[w].rrs_id = in_rrs_id;
            acc[w].tmask  = '0;
            acc[w].data   = '0;
            acc_wid[w]    = in_wid;
        end
        acc[w].tmask[p] = in_tmask[0];
        acc[w].data[p*XLEN +: XLEN] = in_data;
        if (in_eop) begin
            exp_q.push_back('{c: acc[w], wid: acc_wid[w]});
            act[w] = 1'b0;
        end else begin
            act[w] = 1'b1;
        end
    endtask

    task automatic drive(input int w, input bit sop, input bit eop,
                         input int pid, input bit tm,
                         input logic [XLEN-1:0] d,
                         input logic [UUID_WIDTH-1:0] u,
                         input logic [PC_BITS-1:0] pc,
                         input logic [NR_BITS-1:0] rd);
        in_valid  = 1'b1;
        in_wid    = 2'(w);
        in_sop    = sop;
        in_eop    = eop;
        in_pid    = PA'(pid);
        in_tmask  = tm;
        in_data   = d;
        in_uuid   = u;
        in_pc     = pc;
        in_rd     = rd;
        in_wb     = rd[0];
        in_rrs_id = 2'(w);
    endtask

    task automatic accept(input bit rnd);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                chk("accept_timeout", 1'b0, 1'b1);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic send(input int w, input bit sop, input bit eop,
                        input int pid, input bit tm,
                        input logic [XLEN-1:0] d,
                        input logic [UUID_WIDTH-1:0] u,
                        input logic [PC_BITS-1:0] pc,
                        input logic [NR_BITS-1:0] rd);
        drive(w, sop, eop, pid, tm, d, u, pc, rd);
        accept(1'b0);
    endtask

    task automatic do_reset();
        mon_en   = 1'b0;
        in_valid = 1'b0;
        reset    = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete();
        for (int w = 0; w < NW; w++) act[w] = 1'b0;
        exp_err = 1'b0;
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [UUID_WIDTH-1:0] ru[NW];
        logic [PC_BITS-1:0]    rp[NW];
        logic [NR_BITS-1:0]    rr[NW];
        int                    nxt[NW];
        logic [DW-1:0]         bd[6];
        logic [3:0]            bm[6];
        logic [UUID_WIDTH-1:0] bu[6];
        logic [PC_BITS-1:0]    bp[6];
        logic [1:0]            bw[6];

        in_valid = 0; in_wid = 0; in_sop = 0; in_eop = 0; in_pid = 0;
        in_tmask = 0; in_data = 0; in_uuid = 0; in_pc = 0; in_rd = 0;
        in_wb = 0; in_rrs_id = 0; out_ready = 1;
        b_in_valid = 0; b_in_wid = 0; b_in_sop = 0; b_in_eop = 0;
        b_in_pid = 0; b_in_tmask = 0; b_in_data = 0; b_in_uuid = 0;
        b_in_pc = 0; b_in_rd = 0; b_in_wb = 0; b_in_rrs_id = 0;
        b_out_ready = 1;
        exp_err = 0;
        reset = 0;
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_b_valid", b_out_valid, 1'b0);
        @(posedge clk);
        #1;

        // four single-lane packets to warp 2
        send(2, 1, 0, 0, 1, 32'h11, 44'h123, 30'h100, 6'd5);
        send(2, 0, 0, 1, 1, 32'h22, 44'h0, 30'h0, 6'd0);
        send(2, 0, 0, 2, 1, 32'h33, 44'h0, 30'h0, 6'd0);
        send(2, 0, 1, 3, 1, 32'h44, 44'h0, 30'h0, 6'd0);
        in_valid = 0;
        @(negedge clk);
        chk("seq_valid", out_valid, 1'b1);
        chk("seq_tmask", out_tmask, 4'b1111);
        chk("seq_data", out_data, 128'h00000044_00000033_00000022_00000011);
        chk("seq_rd", out_rd, 6'd5);
        chk("seq_pc", out_pc, 30'h100);
        @(posedge clk);
        #1;

        // interleaved warps 0 and 1
        for (int p = 0; p < 4; p++) begin
            send(0, p == 0, p == 3, p, 1, 32'hA0 + p, 44'hA, 30'h10, 6'd1);
            send(1, p == 0, p == 3, p, p != 2, 32'hB0 + p, 44'hB,
                 30'h20, 6'd2);
        end
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1;

        // stall: result held, non-eop still accepted, eop blocked
        for (int p = 0; p < 4; p++)
            send(3, p == 0, p == 3, p, 1, 32'hC0 + p, 44'hC, 30'h30, 6'd3);
        out_ready = 0;
        for (int p = 0; p < 3; p++)
            send(1, p == 0, 0, p, 1, 32'hD0 + p, 44'hD, 30'h40, 6'd4);
        drive(1, 0, 1, 3, 1, 32'hD3, 44'h0, 30'h0, 6'd0);
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_hold_uuid", out_uuid, 44'hC);
        end
        @(posedge clk);
        #1;
        out_ready = 1;
        accept(1'b0);
        in_valid = 0;
        @(negedge clk);
        chk("reload_valid", out_valid, 1'b1);
        chk("reload_uuid", out_uuid, 44'hD);
        @(posedge clk);
        #1;

        // protocol errors
        send(3, 0, 0, 1, 1, 32'hE1, 44'hE, 30'h50, 6'd6);
        in_valid = 0;
        @(negedge clk);
        chk("perr_set", err, 1'b1);
        chk("perr_noout", out_valid, 1'b0);
        @(posedge clk);
        #1;
        send(2, 0, 1, 3, 1, 32'hE3, 44'hE, 30'h50, 6'd6);
        send(0, 1, 0, 0, 1, 32'hF0, 44'hF0, 30'h60, 6'd7);
        send(0, 1, 0, 0, 1, 32'hF8, 44'hF8, 30'h68, 6'd8);
        for (int p = 1; p < 4; p++)
            send(0, 0, p == 3, p, 1, 32'hF8 + p, 44'h0, 30'h0, 6'd0);
        in_valid = 0;
        @(negedge clk);
        chk("restart_uuid", out_uuid, 44'hF8);
        chk("err_sticky", err, 1'b1);
        @(posedge clk);
        #1;

        // reset in the middle of an instruction
        send(2, 1, 0, 0, 1, 32'h51, 44'h51, 30'h70, 6'd9);
        send(2, 0, 0, 1, 1, 32'h52, 44'h0, 30'h0, 6'd0);
        do_reset();
        @(negedge clk);
        chk("rst2_err", err, 1'b0);
        @(posedge clk);
        #1;
        send(2, 0, 0, 2, 1, 32'h53, 44'h0, 30'h0, 6'd0);
        for (int p = 0; p < 4; p++)
            send(2, p == 0, p == 3, p, 1, 32'h61 + p, 44'h61, 30'h71, 6'd10);
        in_valid = 0;
        @(negedge clk);
        chk("rst2_tmask", out_tmask, 4'b1111);
        chk("rst2_uuid", out_uuid, 44'h61);
        chk("rst2_err_after", err, 1'b1);
        @(posedge clk);
        #1;
        do_reset();

        // random interleaved traffic with random backpressure
        for (int w = 0; w < NW; w++) nxt[w] = 0;
        repeat (120) begin
            int w;
            w = $urandom_range(0, NW - 1);
            if (nxt[w] == 0) begin
                ru[w] = UUID_WIDTH'({$urandom(), $urandom()});
                rp[w] = PC_BITS'($urandom());
                rr[w] = NR_BITS'($urandom());
            end
            out_ready = 1'($urandom_range(0, 1));
            drive(w, nxt[w] == 0, nxt[w] == 3, nxt[w],
                  1'($urandom_range(0, 1)), $urandom(), ru[w], rp[w], rr[w]);
            accept(1'b1);
            nxt[w] = (nxt[w] + 1) % 4;
        end
        out_ready = 1;
        for (int w = 0; w < NW; w++) begin
            while (nxt[w] != 0) begin
                send(w, 0, nxt[w] == 3, nxt[w], 1, $urandom(),
                     ru[w], rp[w], rr[w]);
                nxt[w] = (nxt[w] + 1) % 4;
            end
        end
        in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rand_drained", exp_q.size(), 0);

        // full-width instance: registered pass-through
        for (int k = 0; k <= 6; k++) begin
            if (k < 6) begin
                bd[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
                bm[k] = 4'($urandom_range(1, 15));
                bu[k] = UUID_WIDTH'({$urandom(), $urandom()});
                bp[k] = PC_BITS'($urandom());
                bw[k] = 2'($urandom_range(0, 3));
                b_in_valid = 1; b_in_sop = 1; b_in_eop = 1; b_in_pid = 0;
                b_in_data = bd[k]; b_in_tmask = bm[k]; b_in_uuid = bu[k];
                b_in_pc = bp[k]; b_in_wid = bw[k];
                b_in_rd = 6'(k); b_in_wb = 1; b_in_rrs_id = 2'(k);
            end else begin
                b_in_valid = 0;
            end
            @(negedge clk);
            if (k < 6) chk("b_in_ready", b_in_ready, 1'b1);
            if (k > 0) begin
                chk("b_valid", b_out_valid, 1'b1);
                chk("b_data", b_out_data, bd[k-1]);
                chk("b_tmask", b_out_tmask, bm[k-1]);
                chk("b_uuid", b_out_uuid, bu[k-1]);
                chk("b_pc", b_out_pc, bp[k-1]);
                chk("b_wid", b_out_wid, bw[k-1]);
                chk("b_rd", b_out_rd, 6'(k - 1));
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("b_idle", b_out_valid, 1'b0);
        chk("b_err", b_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_commit_gather.md
Name: muldiv_commit_gather

Overview:
- Sits directly downstream of the ALU mul/div unit's commit stream.
- Reassembles the NUM_LANES-wide partial commit packets of one instruction (sop/pid/eop sequence) into a single full-warp writeback of NUM_THREADS lanes.
- Keeps one context per warp and emits through a single registered output with a valid/ready handshake.

Parameters:
- NUM_WARPS, 4, number of warp contexts
- NUM_THREADS, 4, threads per warp (output lane count)
- NUM_LANES, 1, lanes per input packet; NUM_THREADS is a multiple of NUM_LANES
- XLEN, 32, data width per lane
- UUID_WIDTH, 44, instruction uuid width
- PC_BITS, 30, PC width
- NR_BITS, 6, register index width
- RRS_WIS_W, 2, rrs_id width
- PID_WIDTH, max(1, clog2(NUM_THREADS/NUM_LANES)), packet index width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  input packet valid
- in_ready  out  1  input packet accepted
- in_uuid  in  UUID_WIDTH  instruction uuid
- in_wid  in  clog2(NUM_WARPS)  warp id
- in_tmask  in  NUM_LANES  lane mask
- in_PC  in  PC_BITS  PC
- in_rd  in  NR_BITS  destination register
- in_wb  in  1  writeback enable
- in_pid  in  PID_WIDTH  packet index
- in_sop, in_eop  in  1 each  first / last packet of the instruction
- in_rrs_id  in  RRS_WIS_W  rrs id
- in_data  in  NUM_LANES*XLEN  lane results
- out_valid  out  1  merged result valid
- out_ready  in  1  consumer ready
- out_uuid, out_wid, out_PC, out_rd, out_wb, out_rrs_id  out  widths as inputs  latched at sop
- out_tmask  out  NUM_THREADS  merged mask
- out_data  out  NUM_THREADS*XLEN  merged data
- err  out  1  sticky protocol error

Behaviour:
- Input contract: packets of one instruction for a given wid arrive in pid order, sop first, eop last. Packets of different warps may interleave.
- Context[w] state machine:
  - IDLE -> ACCUM on accepted sop without eop.
  - ACCUM -> IDLE on accepted eop.
  - sop&eop in IDLE stays IDLE and emits directly.
- Context fields: uuid, PC, rd, wb and rrs_id are latched on sop. tmask is cleared on sop, then the packet's lanes are written.
- Lane placement: out lane pid*NUM_LANES+i takes in lane i (tmask and data). Lanes not covered by any packet have tmask=0 and data unspecified.
- On accepted eop, the output register loads the context merged with the current packet (bypass, no extra cycle). Latency is eop accept at edge N -> out_valid high after edge N.
- in_ready = ~in_eop | ~out_valid | out_ready. Non-eop packets are always accepted.
- The output register holds all values stable while out_valid & ~out_ready, and may be reloaded in the same cycle it drains. Throughput is one merged result per cycle.
- Protocol errors (err set, sticky until reset):
  - Non-sop packet to an IDLE context: packet dropped, and if eop, nothing is emitted.
  - sop to an ACCUM context: context restarts from the new packet.
- When NUM_THREADS==NUM_LANES, every packet is sop&eop, pid=0, giving a registered pass-through.
- Reset (reset==0 at posedge): out_valid=0, err=0, all contexts IDLE, context tmasks 0. Data/tag registers are not reset. Reset mid-accumulation discards partial contexts.
- No combinational path from in_* to out_*. in_ready depends combinationally on out_ready.

Decomposition:
- Shared package: gather_ctx_t (uuid, PC, rd, wb, rrs_id, tmask, data), the derived PID_WIDTH, and the context state enum (IDLE, ACCUM).
- One sub-module, muldiv_gather_ctx: a single warp context (state, latch, lane write). Instantiated NUM_WARPS times. The output register and err logic stay in the top level.

Test Plan:
- NUM_LANES=1, NUM_THREADS=4, wid=2: pids 0..3 with data 0x11,0x22,0x33,0x44, tmask=1 each -> one output one cycle after eop: tmask=4'b1111, data={0x44,0x33,0x22,0x11}, rd/PC from the sop packet.
- Interleave wid0 and wid1 packets (w0p0, w1p0, w0p1, w1p1, ...) -> two outputs, each containing only its own warp's data, in eop order.
- Hold out_ready=0 with a result pending; send a non-eop packet then an eop packet -> non-eop accepted, eop stalled with in_ready=0; out_ready=1 -> drain and reload in the same cycle.
- pid=1 packet with sop=0 to an IDLE warp -> err=1 next cycle, no output; later normal traffic is still correct and err stays 1.
- Config NUM_LANES=NUM_THREADS=4: back-to-back sop&eop packets with out_ready=1 -> one output per cycle, 1-cycle latency, data identical to input.
- Reset asserted after 2 of 4 pids, then released and a full sequence sent -> only the new instruction is emitted, with tmask=4'b1111.
